// File: rtl/data_mem_be_pkg.sv
// -----------------------------------------------------------------------------
// data_mem_be_pkg
// Shared definitions for the MEM-stage data memory:
//   - RV32 load/store width codes (funct3)
//   - state encoding for the post-reset clear state machine
// No ports; imported by data_mem_be and data_mem_lane_fmt.
// -----------------------------------------------------------------------------
package data_mem_be_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

endpackage

// File: rtl/data_mem_lane_fmt.sv
// -----------------------------------------------------------------------------
// data_mem_lane_fmt
// Purely combinational lane formatter for byte-addressable 32-bit memory.
// Ports:
//   funct3     in  3   RV32 width/sign code
//   addr_lo    in  2   byte offset within the word (addr[1:0])
//   store_data in  32  raw store data (low byte/half used for B/H)
//   rdata      in  32  current contents of the addressed word
//   fault      out 1   misaligned access or illegal funct3
//   byte_en    out 4   lanes to write (all zero on a fault)
//   wdata      out 32  store data replicated across lanes
//   load_data  out 32  extracted, extended load result (zero on a fault)
// -----------------------------------------------------------------------------
module data_mem_lane_fmt
  import data_mem_be_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic        fault,
  output logic [3:0]  byte_en,
  output logic [31:0] wdata,
  output logic [31:0] load_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = rdata[{addr_lo, 3'b000} +: 8];
  assign half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

  // BU/HU used with a store behave as B/H stores: the width comes from
  // funct3[1:0], only the illegal codes fault regardless of direction.
  always_comb begin
    fault     = 1'b0;
    byte_en   = 4'b0000;
    wdata     = store_data;
    load_data = '0;
    case (funct3)
      F3_B, F3_BU: begin
        byte_en   = 4'b0001 << addr_lo;
        wdata     = {4{store_data[7:0]}};
        load_data = funct3[2] ? {24'h0, byte_sel}
                              : {{24{byte_sel[7]}}, byte_sel};
      end
      F3_H, F3_HU: begin
        wdata = {2{store_data[15:0]}};
        if (addr_lo[0]) begin
          fault = 1'b1;
        end else begin
          byte_en   = addr_lo[1] ? 4'b1100 : 4'b0011;
          load_data = funct3[2] ? {16'h0, half_sel}
                                : {{16{half_sel[15]}}, half_sel};
        end
      end
      F3_W: begin
        if (addr_lo != 2'b00) begin
          fault = 1'b1;
        end else begin
          byte_en   = 4'b1111;
          load_data = rdata;
        end
      end
      default: fault = 1'b1;
    endcase
  end

endmodule

// File: rtl/data_mem_be.sv
// -----------------------------------------------------------------------------
// data_mem_be
// Byte-addressable data memory for the MEM stage of an RV32 pipeline.
// After reset the array is zeroed one word per cycle (o_busy high), then the
// memory serves B/H/W loads and stores with byte-lane writes.
// Ports:
//   i_clk       in  1            clock, rising edge
//   i_rst_n     in  1            asynchronous reset, active low
//   i_we        in  1            store request
//   i_re        in  1            load request
//   i_funct3    in  3            width/sign code (B,H,W,BU,HU)
//   i_addr      in  32           byte address (wraps modulo DEPTH_WORDS*4)
//   i_data      in  32           store data
//   o_data      out 32           load result, extended
//   o_misalign  out 1            access fault
//   o_busy      out 1            post-reset clear in progress
//   o_taps      out 32*NUM_TAPS  words 0..NUM_TAPS-1, straight from the array
// -----------------------------------------------------------------------------
module data_mem_be
  import data_mem_be_pkg::*;
#(
  parameter int DEPTH_WORDS  = 32,
  parameter int NUM_TAPS     = 3,
  parameter int READ_LATENCY = 0
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_we,
  input  logic                  i_re,
  input  logic [2:0]            i_funct3,
  input  logic [31:0]           i_addr,
  input  logic [31:0]           i_data,
  output logic [31:0]           o_data,
  output logic                  o_misalign,
  output logic                  o_busy,
  output logic [32*NUM_TAPS-1:0] o_taps
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH_WORDS - 1);

  logic [31:0]   mem [DEPTH_WORDS];
  state_t        state, state_nxt;
  logic [AW-1:0] clr_idx, clr_idx_nxt;
  logic          busy;
  logic [AW-1:0] word_idx;
  logic [31:0]   rdata;
  logic [31:0]   wdata;
  logic [31:0]   load_data;
  logic [3:0]    byte_en;
  logic          fault;
  logic          access;
  logic          store_en;
  logic          unused_addr_hi;

  // Upper address bits are dropped so accesses wrap around the array.
  assign word_idx       = i_addr[AW+1:2];
  assign unused_addr_hi = ^i_addr[31:AW+2];
  assign rdata          = mem[word_idx];
  assign busy           = (state == ST_CLEAR);
  assign access         = i_we | i_re;
  assign store_en       = i_we & ~fault & ~busy;
  assign o_busy         = busy;

  data_mem_lane_fmt u_lane_fmt (
    .funct3     (i_funct3),
    .addr_lo    (i_addr[1:0]),
    .store_data (i_data),
    .rdata      (rdata),
    .fault      (fault),
    .byte_en    (byte_en),
    .wdata      (wdata),
    .load_data  (load_data)
  );

  // Clear state machine register: reset always restarts the sweep at word 0.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= ST_CLEAR;
      clr_idx <= '0;
    end else begin
      state   <= state_nxt;
      clr_idx <= clr_idx_nxt;
    end
  end

  // The edge that writes the last word also leaves CLEAR, so the sweep
  // occupies exactly DEPTH_WORDS cycles.
  always_comb begin
    state_nxt   = state;
    clr_idx_nxt = clr_idx;
    case (state)
      ST_CLEAR: begin
        clr_idx_nxt = clr_idx + AW'(1);
        if (clr_idx == LAST_IDX) begin
          state_nxt = ST_READY;
        end
      end
      ST_READY: state_nxt = ST_READY;
    endcase
  end

  // Array write port: the clear sweep owns the array while busy, otherwise
  // stores update only the enabled byte lanes.
  always_ff @(posedge i_clk) begin
    if (busy) begin
      mem[clr_idx] <= '0;
    end else if (store_en) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) begin
          mem[word_idx][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  generate
    if (READ_LATENCY == 0) begin : g_comb_read
      assign o_data     = busy ? '0 : load_data;
      assign o_misalign = ~busy & access & fault;
    end else begin : g_reg_read
      logic [31:0] data_q;
      logic        mis_q;

      // Registered read samples the pre-edge array, so a same-cycle store
      // is not seen until the following load.
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          data_q <= '0;
          mis_q  <= 1'b0;
        end else if (busy) begin
          data_q <= '0;
          mis_q  <= 1'b0;
        end else if (i_re) begin
          data_q <= load_data;
          mis_q  <= fault;
        end else begin
          mis_q  <= i_we & fault;
        end
      end

      assign o_data     = data_q;
      assign o_misalign = mis_q;
    end

    for (genvar k = 0; k < NUM_TAPS; k++) begin : g_taps
      assign o_taps[32*k +: 32] = mem[k];
    end
  endgenerate

endmodule

// File: tb/tb_data_mem_be.sv
// -----------------------------------------------------------------------------
// tb_data_mem_be
// Self-checking bench driving two copies of data_mem_be (combinational and
// registered read) with the same stimulus, compared against a byte-level
// reference model of the memory.
// -----------------------------------------------------------------------------
module tb_data_mem_be;

  localparam int DEPTH = 32;
  localparam int TAPS  = 3;

  logic        clk;
  logic        rst_n;
  logic        we;
  logic        re;
  logic [2:0]  f3;
  logic [31:0] addr;
  logic [31:0] wr_data;

  logic [31:0]        data0, data1;
  logic               mis0, mis1;
  logic               busy0, busy1;
  logic [32*TAPS-1:0] taps0, taps1;

  int checks = 0;
  int errors = 0;

  logic [31:0] model_mem [DEPTH];
  logic [31:0] exp1_data;
  logic        exp1_mis;

  typedef struct {
    logic        we;
    logic        re;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp_data;
    logic        exp_mis;
  } vec_t;

  vec_t vecs [21];

  data_mem_be #(.DEPTH_WORDS(DEPTH), .NUM_TAPS(TAPS), .READ_LATENCY(0)) dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_we(we), .i_re(re), .i_funct3(f3),
    .i_addr(addr), .i_data(wr_data), .o_data(data0), .o_misalign(mis0),
    .o_busy(busy0), .o_taps(taps0)
  );

  data_mem_be #(.DEPTH_WORDS(DEPTH), .NUM_TAPS(TAPS), .READ_LATENCY(1)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_we(we), .i_re(re), .i_funct3(f3),
    .i_addr(addr), .i_data(wr_data), .o_data(data1), .o_misalign(mis1),
    .o_busy(busy1), .o_taps(taps1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something wedges the stimulus thread.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference model: access size in bytes from the width code.
  function automatic int access_size(input logic [2:0] code);
    return 1 << code[1:0];
  endfunction

  function automatic logic model_fault(input logic [2:0] code, input logic [31:0] a);
    if (code == 3'd3 || code == 3'd6 || code == 3'd7) return 1'b1;
    return (a % access_size(code)) != 0;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] code, input logic [31:0] a);
    longint unsigned w, v;
    int sz;
    if (model_fault(code, a)) return 32'h0;
    sz = access_size(code);
    w  = longint'(model_mem[(a / 4) % DEPTH]);
    v  = (w >> (8 * (a % 4))) % (64'd1 << (8 * sz));
    if (code[2] == 1'b0 && sz < 4 && v >= (64'd1 << (8 * sz - 1)))
      v = v + (64'h1_0000_0000 - (64'd1 << (8 * sz)));
    return v[31:0];
  endfunction

  function automatic void model_store(input logic [2:0] code, input logic [31:0] a,
                                      input logic [31:0] d);
    int idx, lane;
    logic [31:0] w, bv;
    idx = (a / 4) % DEPTH;
    w   = model_mem[idx];
    for (int i = 0; i < access_size(code); i++) begin
      lane = (a % 4) + i;
      bv   = (d >> (8 * i)) & 32'hFF;
      w    = (w & ~(32'hFF << (8 * lane))) | (bv << (8 * lane));
    end
    model_mem[idx] = w;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // One bus cycle: drive, check everything at the falling edge, then advance
  // the model across the rising edge.
  task automatic applyStimulus(input logic s_we, input logic s_re, input logic [2:0] s_f3,
                               input logic [31:0] s_addr, input logic [31:0] s_data,
                               output logic [31:0] got_data, output logic got_mis);
    logic        flt;
    logic [31:0] exp0;
    we = s_we; re = s_re; f3 = s_f3; addr = s_addr; wr_data = s_data;
    @(negedge clk);
    flt  = model_fault(s_f3, s_addr);
    exp0 = model_load(s_f3, s_addr);
    got_data = data0;
    got_mis  = mis0;
    checkOutput("lat0_data", data0, exp0);
    checkOutput("lat0_misalign", 32'(mis0), 32'(flt & (s_we | s_re)));
    checkOutput("lat1_data", data1, exp1_data);
    checkOutput("lat1_misalign", 32'(mis1), 32'(exp1_mis));
    checkOutput("ready_busy", 32'({busy0, busy1}), 32'd0);
    for (int k = 0; k < TAPS; k++) begin
      checkOutput($sformatf("lat0_tap%0d", k), taps0[32*k +: 32], model_mem[k]);
      checkOutput($sformatf("lat1_tap%0d", k), taps1[32*k +: 32], model_mem[k]);
    end
    @(posedge clk);
    if (s_re) begin
      exp1_data = exp0;
      exp1_mis  = flt;
    end else begin
      exp1_mis  = s_we & flt;
    end
    if (s_we && !flt) model_store(s_f3, s_addr, s_data);
    #1;
  endtask

  // Reset, optionally re-asserted abort_at cycles into the clear, then count
  // busy cycles while hammering the memory with requests that must be ignored.
  task automatic doReset(input int abort_at);
    int cnt;
    rst_n = 1'b0; we = 1'b0; re = 1'b0; f3 = 3'b010; addr = '0; wr_data = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_busy", 32'({busy0, busy1}), 32'd3);
    checkOutput("rst_lat0_data", data0, 32'h0);
    checkOutput("rst_lat1_data", data1, 32'h0);
    checkOutput("rst_misalign", 32'({mis0, mis1}), 32'd0);
    rst_n = 1'b1;
    if (abort_at > 0) begin
      repeat (abort_at) @(posedge clk);
      #1;
      checkOutput("midclear_busy", 32'(busy0), 32'd1);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
    end
    we = 1'b1; re = 1'b1; f3 = 3'b010; wr_data = 32'hCAFEF00D;
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      addr = (cnt % 2 == 0) ? 32'h0 : 32'h1;
      @(negedge clk);
      if (!busy0) break;
      cnt++;
      checkOutput("clear_lat1_busy", 32'(busy1), 32'd1);
      checkOutput("clear_data", data0 | data1, 32'h0);
      checkOutput("clear_misalign", 32'({mis0, mis1}), 32'd0);
    end
    we = 1'b0; re = 1'b0;
    checkOutput("clear_cycles", 32'(cnt), 32'd32);
    @(posedge clk);
    #1;
    for (int k = 0; k < DEPTH; k++) model_mem[k] = 32'h0;
    exp1_data = 32'h0;
    exp1_mis  = 1'b0;
  endtask

  initial begin
    logic [31:0] gd;
    logic        gm;
    logic [31:0] unused_d;
    logic        unused_m;

    vecs[0]  = '{1'b1, 1'b0, 3'b010, 32'h4,   32'h8899AABB, 32'h00000000, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 3'b000, 32'h7,   32'h0,        32'hFFFFFF88, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 3'b100, 32'h7,   32'h0,        32'h00000088, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 3'b001, 32'h6,   32'h0,        32'hFFFF8899, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 3'b101, 32'h4,   32'h0,        32'h0000AABB, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 3'b000, 32'h5,   32'h11,       32'hFFFFFFAA, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 3'b010, 32'h4,   32'h0,        32'h889911BB, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 3'b001, 32'h3,   32'h1234,     32'h00000000, 1'b1};
    vecs[8]  = '{1'b1, 1'b0, 3'b010, 32'h2,   32'hCAFEBABE, 32'h00000000, 1'b1};
    vecs[9]  = '{1'b0, 1'b1, 3'b010, 32'h4,   32'h0,        32'h889911BB, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 3'b010, 32'h1,   32'h0,        32'h00000000, 1'b1};
    vecs[11] = '{1'b0, 1'b1, 3'b011, 32'h0,   32'h0,        32'h00000000, 1'b1};
    vecs[12] = '{1'b0, 1'b0, 3'b011, 32'h0,   32'h0,        32'h00000000, 1'b0};
    vecs[13] = '{1'b1, 1'b0, 3'b001, 32'h6,   32'hBEEF,     32'hFFFF8899, 1'b0};
    vecs[14] = '{1'b0, 1'b1, 3'b101, 32'h6,   32'h0,        32'h0000BEEF, 1'b0};
    vecs[15] = '{1'b0, 1'b1, 3'b000, 32'h4,   32'h0,        32'hFFFFFFBB, 1'b0};
    vecs[16] = '{1'b1, 1'b0, 3'b010, 32'h80,  32'hDEADBEEF, 32'h00000000, 1'b0};
    vecs[17] = '{1'b0, 1'b1, 3'b010, 32'h0,   32'h0,        32'hDEADBEEF, 1'b0};
    vecs[18] = '{1'b0, 1'b1, 3'b010, 32'h100, 32'h0,        32'hDEADBEEF, 1'b0};
    vecs[19] = '{1'b1, 1'b1, 3'b010, 32'hC,   32'h77,       32'h00000000, 1'b0};
    vecs[20] = '{1'b0, 1'b1, 3'b010, 32'hC,   32'h0,        32'h00000077, 1'b0};

    doReset(0);

    // Registered read: same-cycle store and load returns the old word.
    applyStimulus(1'b1, 1'b1, 3'b010, 32'h8, 32'h5, unused_d, unused_m);
    checkOutput("lat1_same_cycle_old", data1, 32'h0);
    applyStimulus(1'b0, 1'b1, 3'b010, 32'h8, 32'h0, unused_d, unused_m);
    checkOutput("lat1_repeat_new", data1, 32'h5);
    applyStimulus(1'b0, 1'b0, 3'b010, 32'h8, 32'h0, unused_d, unused_m);
    checkOutput("lat1_hold_idle", data1, 32'h5);
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h10, 32'h123, unused_d, unused_m);
    checkOutput("lat1_hold_store", data1, 32'h5);

    for (int i = 0; i < 21; i++) begin
      applyStimulus(vecs[i].we, vecs[i].re, vecs[i].f3, vecs[i].addr, vecs[i].data, gd, gm);
      checkOutput($sformatf("vec%0d_data", i), gd, vecs[i].exp_data);
      checkOutput($sformatf("vec%0d_misalign", i), 32'(gm), 32'(vecs[i].exp_mis));
    end

    doReset(10);

    for (int i = 0; i < 400; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    3'($urandom_range(0, 7)), 32'($urandom_range(0, 255)),
                    $urandom, unused_d, unused_m);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
